// File: rtl/seq_alu_core.sv
// ---------------------------------------------------------------------------
// seq_alu_core
//
// Execution stage that sits after the 8-bit register file. It takes operands
// a/b and an opcode on y, and returns a registered 2*WIDTH-bit result that is
// written back into the register file.
//
// Opcodes (y[2:0], upper bits of y are not decoded):
//   0 ADD  {0.., carry, a+b}      4 XOR  {0.., a^b}
//   1 SUB  {0.., borrow, a-b}     5 MUL  a*b (shift-add, ITER cycles)
//   2 AND  {0.., a&b}             6 DIV  {rem, quot} (restoring, ITER cycles)
//   3 OR   {0.., a|b}             7 NOT  {0.., ~a}
//
// Ports:
//   clock    in   system clock, rising edge
//   reset_n  in   asynchronous active-low reset
//   a, b     in   operands (WIDTH bits)
//   y        in   opcode (WIDTH bits, only [2:0] used)
//   start    in   request, honoured only when idle
//   result   out  registered result (2*WIDTH bits), held between completions
//   done     out  one-cycle pulse, coincides with the result update
//   busy     out  high while a multiply or divide is iterating
//   err      out  divide-by-zero flag, cleared by the next accepted start
// ---------------------------------------------------------------------------
module seq_alu_core #(
  parameter int WIDTH = 8,
  parameter int ITER  = 8
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [WIDTH-1:0]   y,
  input  logic               start,
  output logic [2*WIDTH-1:0] result,
  output logic               done,
  output logic               busy,
  output logic               err
);

  localparam int RW = 2 * WIDTH;
  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(ITER - 1);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_MUL = 3'd5;
  localparam logic [2:0] OP_DIV = 3'd6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg,   cnt_next;
  // MUL: multiplicand, shifted left once per iteration.
  // DIV: divisor, held in the low WIDTH bits.
  logic [RW-1:0]   opa_reg,   opa_next;
  // MUL: multiplier, shifted right so bit 0 is the current multiplier bit.
  // DIV: dividend shifting out of the top while quotient bits enter below.
  logic [WIDTH-1:0] shf_reg,  shf_next;
  // MUL: partial-product accumulator. DIV: partial remainder in the low bits.
  logic [RW-1:0]   acc_reg,   acc_next;
  logic [RW-1:0]   result_reg, result_next;
  logic            done_reg,  done_next;
  logic            busy_reg,  busy_next;
  logic            err_reg,   err_next;

  logic [2:0]      op;
  logic            unused_y_hi;

  assign op          = y[2:0];
  assign unused_y_hi = ^y[WIDTH-1:3];

  // -------------------------------------------------------------------------
  // Single-cycle datapath (operates directly on the live inputs; the result
  // is captured on the same edge that accepts start).
  // -------------------------------------------------------------------------
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   diff_ext;
  logic [WIDTH-1:0] logic_res;

  // The extra top bit is carry for ADD and borrow (a < b) for SUB.
  assign sum_ext  = {1'b0, a} + {1'b0, b};
  assign diff_ext = {1'b0, a} - {1'b0, b};

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_logic
    assign logic_res[gi] = (op == OP_AND) ? (a[gi] & b[gi]) :
                           (op == OP_OR)  ? (a[gi] | b[gi]) :
                           (op == OP_XOR) ? (a[gi] ^ b[gi]) :
                                            ~a[gi];
  end

  // -------------------------------------------------------------------------
  // Iterative datapath
  // -------------------------------------------------------------------------
  logic [RW-1:0]    mul_sum;
  logic [WIDTH:0]   div_trial;
  logic [WIDTH:0]   div_sub;
  logic             div_fit;
  logic [WIDTH-1:0] div_rem;

  assign mul_sum = shf_reg[0] ? (acc_reg + opa_reg) : acc_reg;

  // Restoring step: shift the next dividend bit into the partial remainder
  // and try to subtract the divisor. Because the remainder is always below
  // the divisor, a successful trial subtraction is below 2^WIDTH, so the top
  // bit of div_sub is exactly the borrow.
  assign div_trial = {acc_reg[WIDTH-1:0], shf_reg[WIDTH-1]};
  assign div_sub   = div_trial - {1'b0, opa_reg[WIDTH-1:0]};
  assign div_fit   = ~div_sub[WIDTH];
  assign div_rem   = div_fit ? div_sub[WIDTH-1:0] : div_trial[WIDTH-1:0];

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      opa_reg    <= '0;
      shf_reg    <= '0;
      acc_reg    <= '0;
      result_reg <= '0;
      done_reg   <= 1'b0;
      busy_reg   <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      opa_reg    <= opa_next;
      shf_reg    <= shf_next;
      acc_reg    <= acc_next;
      result_reg <= result_next;
      done_reg   <= done_next;
      busy_reg   <= busy_next;
      err_reg    <= err_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and datapath control
  // -------------------------------------------------------------------------
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    opa_next    = opa_reg;
    shf_next    = shf_reg;
    acc_next    = acc_reg;
    result_next = result_reg;
    done_next   = 1'b0;
    err_next    = err_reg;

    unique case (state_reg)
      IDLE: begin
        if (start) begin
          err_next = 1'b0;
          cnt_next = '0;
          case (op)
            OP_ADD: begin
              result_next = {{(WIDTH-1){1'b0}}, sum_ext};
              done_next   = 1'b1;
            end
            OP_SUB: begin
              result_next = {{(WIDTH-1){1'b0}}, diff_ext};
              done_next   = 1'b1;
            end
            OP_MUL: begin
              state_next = MUL;
              opa_next   = {{WIDTH{1'b0}}, a};
              shf_next   = b;
              acc_next   = '0;
            end
            OP_DIV: begin
              if (b == '0) begin
                result_next = '1;
                err_next    = 1'b1;
                done_next   = 1'b1;
              end else begin
                state_next = DIV;
                opa_next   = {{WIDTH{1'b0}}, b};
                shf_next   = a;
                acc_next   = '0;
              end
            end
            default: begin
              // AND, OR, XOR, NOT share the bitwise unit.
              result_next = {{WIDTH{1'b0}}, logic_res};
              done_next   = 1'b1;
            end
          endcase
        end
      end

      MUL: begin
        acc_next = mul_sum;
        opa_next = opa_reg << 1;
        shf_next = shf_reg >> 1;
        cnt_next = cnt_reg + CW'(1);
        if (cnt_reg == LAST_ITER) begin
          result_next = mul_sum;
          done_next   = 1'b1;
          state_next  = IDLE;
          cnt_next    = '0;
        end
      end

      DIV: begin
        acc_next = {{WIDTH{1'b0}}, div_rem};
        shf_next = {shf_reg[WIDTH-2:0], div_fit};
        cnt_next = cnt_reg + CW'(1);
        if (cnt_reg == LAST_ITER) begin
          result_next = {div_rem, shf_reg[WIDTH-2:0], div_fit};
          done_next   = 1'b1;
          state_next  = IDLE;
          cnt_next    = '0;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    busy_next = (state_next != IDLE);
  end

  assign result = result_reg;
  assign done   = done_reg;
  assign busy   = busy_reg;
  assign err    = err_reg;

endmodule

// File: tb/tb_seq_alu_core.sv
// ---------------------------------------------------------------------------
// tb_seq_alu_core
//
// Self-checking bench for seq_alu_core: a table of directed vectors with
// hand-computed results, hand-written reset sequences, and a randomized
// phase compared against an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_seq_alu_core;

  logic        clock   = 1'b0;
  logic        reset_n = 1'b0;
  logic        start   = 1'b0;
  logic [7:0]  a       = 8'h00;
  logic [7:0]  b       = 8'h00;
  logic [7:0]  y       = 8'h00;
  logic [15:0] result;
  logic        done;
  logic        busy;
  logic        err;

  int n_assert = 0;
  int n_fail   = 0;

  seq_alu_core #(.WIDTH(8), .ITER(8)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .a       (a),
    .b       (b),
    .y       (y),
    .start   (start),
    .result  (result),
    .done    (done),
    .busy    (busy),
    .err     (err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [2:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [4:0]  yhi;
    logic [15:0] exp_res;
    logic        exp_err;
    logic        idle_after;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: plain integer arithmetic. Returns {err, result}.
  function automatic logic [16:0] model(input logic [2:0] op, input logic [7:0] av, input logic [7:0] bv);
    int   ia = int'(av);
    int   ib = int'(bv);
    int   r  = 0;
    logic e  = 1'b0;
    case (op)
      3'd0: r = ia + ib;
      3'd1: r = ((ia < ib) ? 256 : 0) + ((ia - ib) & 255);
      3'd2: r = ia & ib;
      3'd3: r = ia | ib;
      3'd4: r = ia ^ ib;
      3'd5: r = ia * ib;
      3'd6: begin
        if (ib == 0) begin
          r = 65535;
          e = 1'b1;
        end else begin
          r = (ia % ib) * 256 + ia / ib;
        end
      end
      default: r = 255 - ia;
    endcase
    return {e, r[15:0]};
  endfunction

  // Issue one operation and check its whole lifecycle.
  task automatic exec(input logic [2:0] op, input logic [7:0] av, input logic [7:0] bv,
                      input logic [4:0] yhi, input logic [15:0] exp_res, input logic exp_err,
                      input logic idle_after);
    logic [15:0] prev;
    logic        multi;
    int          lat;
    multi = (op == 3'd5) || (op == 3'd6 && bv != 8'h00);
    @(negedge clock);
    prev  = result;
    a     = av;
    b     = bv;
    y     = {yhi, op};
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    lat   = 1;
    if (!multi) begin
      check("single_done", 32'(done), 32'd1);
      check("single_busy", 32'(busy), 32'd0);
    end else begin
      check("start_busy", 32'(busy), 32'd1);
      check("start_done", 32'(done), 32'd0);
      check("start_err_clear", 32'(err), 32'd0);
      check("start_hold_result", 32'(result), 32'(prev));
      // Operands change after acceptance; the operation must not notice.
      a = 8'($urandom);
      b = 8'($urandom);
      y = 8'($urandom);
      while (done !== 1'b1 && lat < 20) begin
        // A start pulse mid-operation must be ignored, not queued.
        start = (lat == 3);
        if (lat == 3) y = 8'h00;
        @(posedge clock);
        #1;
        lat++;
        start = 1'b0;
        if (done !== 1'b1) begin
          check("mid_hold_result", 32'(result), 32'(prev));
          check("mid_busy", 32'(busy), 32'd1);
        end
      end
      check("latency", 32'(lat), 32'd9);
      check("end_busy", 32'(busy), 32'd0);
    end
    check("result", 32'(result), 32'(exp_res));
    check("err", 32'(err), 32'(exp_err));
    $display("op=%0d a=%02h b=%02h -> result=%04h err=%0b done=%0b edges=%0d (expect %04h err=%0b)",
             op, av, bv, result, err, done, lat, exp_res, exp_err);
    if (idle_after) begin
      prev = result;
      @(posedge clock);
      #1;
      check("done_pulse_width", 32'(done), 32'd0);
      check("idle_hold_result", 32'(result), 32'(prev));
    end
  endtask

  initial begin
    int           stray;
    logic [16:0]  m;
    logic [2:0]   rop;
    logic [7:0]   ra;
    logic [7:0]   rb;

    //            op    a      b      yhi    exp_res   err  idle
    vecs.push_back('{3'd0, 8'd200, 8'd100, 5'h00, 16'h012C, 1'b0, 1'b1});
    vecs.push_back('{3'd1, 8'd5,   8'd10,  5'h00, 16'h01FB, 1'b0, 1'b0});
    vecs.push_back('{3'd7, 8'h0F,  8'h33,  5'h00, 16'h00F0, 1'b0, 1'b1});
    vecs.push_back('{3'd2, 8'hA5,  8'h3C,  5'h1F, 16'h0024, 1'b0, 1'b1});
    vecs.push_back('{3'd3, 8'hA5,  8'h3C,  5'h0A, 16'h00BD, 1'b0, 1'b1});
    vecs.push_back('{3'd4, 8'hA5,  8'h3C,  5'h15, 16'h0099, 1'b0, 1'b1});
    vecs.push_back('{3'd0, 8'hFF,  8'hFF,  5'h00, 16'h01FE, 1'b0, 1'b1});
    vecs.push_back('{3'd1, 8'd10,  8'd5,   5'h00, 16'h0005, 1'b0, 1'b1});
    vecs.push_back('{3'd5, 8'hFF,  8'hFF,  5'h00, 16'hFE01, 1'b0, 1'b1});
    vecs.push_back('{3'd5, 8'd3,   8'd4,   5'h00, 16'h000C, 1'b0, 1'b1});
    vecs.push_back('{3'd5, 8'h00,  8'hAB,  5'h00, 16'h0000, 1'b0, 1'b1});
    vecs.push_back('{3'd6, 8'd200, 8'd7,   5'h00, 16'h041C, 1'b0, 1'b1});
    vecs.push_back('{3'd6, 8'd9,   8'd0,   5'h00, 16'hFFFF, 1'b1, 1'b0});
    vecs.push_back('{3'd0, 8'd1,   8'd1,   5'h00, 16'h0002, 1'b0, 1'b1});
    vecs.push_back('{3'd6, 8'd255, 8'd1,   5'h00, 16'h00FF, 1'b0, 1'b0});
    vecs.push_back('{3'd6, 8'd5,   8'd10,  5'h00, 16'h0500, 1'b0, 1'b1});

    // Reset state
    #12;
    check("reset_result", 32'(result), 32'h0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_err", 32'(err), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    foreach (vecs[i])
      exec(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].yhi,
           vecs[i].exp_res, vecs[i].exp_err, vecs[i].idle_after);

    // Asynchronous reset while idle with err set
    exec(3'd6, 8'd9, 8'd0, 5'h00, 16'hFFFF, 1'b1, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_idle_err", 32'(err), 32'd0);
    check("rst_idle_result", 32'(result), 32'h0);
    @(negedge clock);
    reset_n = 1'b1;

    // Asynchronous reset in the fourth cycle of a divide
    exec(3'd0, 8'h80, 8'h33, 5'h00, 16'h00B3, 1'b0, 1'b0);
    @(negedge clock);
    a = 8'd200; b = 8'd7; y = 8'd6; start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_div_result", 32'(result), 32'h0);
    check("rst_div_busy", 32'(busy), 32'd0);
    check("rst_div_done", 32'(done), 32'd0);
    check("rst_div_err", 32'(err), 32'd0);
    $display("reset during DIV: result=%04h busy=%0b done=%0b err=%0b", result, busy, done, err);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    stray = 0;
    repeat (12) begin
      @(posedge clock);
      #1;
      if (done === 1'b1) stray++;
    end
    check("no_stray_done", 32'(stray), 32'd0);
    exec(3'd0, 8'd1, 8'd1, 5'h00, 16'h0002, 1'b0, 1'b1);

    // Randomized operations against the reference model
    for (int k = 0; k < 80; k++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = 8'($urandom);
      rb  = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      m   = model(rop, ra, rb);
      exec(rop, ra, rb, 5'($urandom), m[15:0], m[16], 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
